// File: rtl/bp_dma_bram_responder_if.sv
// DMA request/data bundle between a bsg_cache style initiator
// and the block-RAM responder.
interface bp_dma_bram_responder_if #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 64
);
    logic [addr_width_p:0]   dma_pkt_i;
    logic                    dma_pkt_v_i;
    logic                    dma_pkt_yumi_o;
    logic [data_width_p-1:0] dma_data_o;
    logic                    dma_data_v_o;
    logic                    dma_data_ready_and_i;
    logic [data_width_p-1:0] dma_data_i;
    logic                    dma_data_v_i;
    logic                    dma_data_yumi_o;

    modport slave (
        input  dma_pkt_i,
        input  dma_pkt_v_i,
        output dma_pkt_yumi_o,
        output dma_data_o,
        output dma_data_v_o,
        input  dma_data_ready_and_i,
        input  dma_data_i,
        input  dma_data_v_i,
        output dma_data_yumi_o
    );

    modport master (
        output dma_pkt_i,
        output dma_pkt_v_i,
        input  dma_pkt_yumi_o,
        input  dma_data_o,
        input  dma_data_v_o,
        output dma_data_ready_and_i,
        output dma_data_i,
        output dma_data_v_i,
        input  dma_data_yumi_o
    );
endinterface

// File: rtl/bp_dma_bram_responder.sv
// Block-RAM backed DMA responder: services one block-sized read or
// write request at a time, beat by beat, from on-chip memory.
module bp_dma_bram_responder #(
    parameter int addr_width_p  = 28,
    parameter int data_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int mem_els_p     = 4096
) (
    input  logic clk_i,
    input  logic reset_active_low_i,
    bp_dma_bram_responder_if.slave dma
);
    localparam int beats_lp    = block_width_p / data_width_p;
    localparam int byte_off_lp = $clog2(data_width_p / 8);
    localparam int blk_off_lp  = $clog2(block_width_p / 8);
    localparam int base_w_lp   = addr_width_p - blk_off_lp;
    localparam int cnt_w_lp    = $clog2(beats_lp + 1);
    localparam int mem_aw_lp   = $clog2(mem_els_p);

    localparam logic [cnt_w_lp-1:0] beats_c = cnt_w_lp'(beats_lp);
    localparam logic [cnt_w_lp-1:0] last_c  = cnt_w_lp'(beats_lp - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_e;

    state_e                  state_q, state_d;
    logic [base_w_lp-1:0]    base_q, base_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic [cnt_w_lp-1:0]     deq_q, deq_d;
    logic                    out_v_q, out_v_d;
    logic [data_width_p-1:0] out_q;

    logic                    mem_re;
    logic                    mem_we;
    logic                    deq;
    logic [mem_aw_lp-1:0]    mem_idx;
    logic [data_width_p-1:0] mem_q [mem_els_p];

    // Offset bits inside a block are deliberately ignored.
    logic unused_addr_lo;
    assign unused_addr_lo = ^dma.dma_pkt_i[blk_off_lp-1:0];

    // Word index of the current beat; wraps modulo the RAM depth.
    assign mem_idx = mem_aw_lp'(
        ({base_q, {blk_off_lp{1'b0}}} >> byte_off_lp)
        + addr_width_p'(cnt_q));

    assign deq            = out_v_q & dma.dma_data_ready_and_i;
    assign dma.dma_data_o   = out_q;
    assign dma.dma_data_v_o = out_v_q;

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d             = state_q;
        base_d              = base_q;
        cnt_d               = cnt_q;
        deq_d               = deq_q;
        out_v_d             = out_v_q;
        mem_re              = 1'b0;
        mem_we              = 1'b0;
        dma.dma_pkt_yumi_o  = 1'b0;
        dma.dma_data_yumi_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                dma.dma_pkt_yumi_o = dma.dma_pkt_v_i;
                if (dma.dma_pkt_v_i) begin
                    base_d = dma.dma_pkt_i[addr_width_p-1:blk_off_lp];
                    cnt_d  = '0;
                    deq_d  = '0;
                    state_d = dma.dma_pkt_i[addr_width_p]
                            ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                dma.dma_data_yumi_o = dma.dma_data_v_i;
                if (dma.dma_data_v_i) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == last_c) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_READ: begin
                // The output slot can accept a new beat when it is empty
                // or is being drained this cycle.
                mem_re = (cnt_q < beats_c) && (!out_v_q || deq);
                if (mem_re) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (deq) begin
                    deq_d = deq_q + 1'b1;
                    if (deq_q == last_c) begin
                        state_d = S_IDLE;
                    end
                end
                if (mem_re) begin
                    out_v_d = 1'b1;
                end else if (deq) begin
                    out_v_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; abandons any transfer on reset.
    always_ff @(posedge clk_i or negedge reset_active_low_i) begin
        if (!reset_active_low_i) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            deq_q   <= '0;
            out_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            deq_q   <= deq_d;
            out_v_q <= out_v_d;
        end
    end

    // Synchronous RAM; its registered read port is the output slot.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_idx] <= dma.dma_data_i;
        end
        if (mem_re) begin
            out_q <= mem_q[mem_idx];
        end
    end
endmodule
